// File: rtl/riscv_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and the data stage.
// One transaction in flight; data wins arbitration unless fetch has waited too long.
module riscv_mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,

  input  logic                if_req_i,
  input  logic [XLEN-1:0]     if_addr_i,
  input  logic                if_flush_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [XLEN-1:0]     if_rdata_o,

  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [XLEN/8-1:0]   d_be_i,
  input  logic [XLEN-1:0]     d_addr_i,
  input  logic [XLEN-1:0]     d_wdata_i,
  output logic                d_gnt_o,
  output logic                d_rvalid_o,
  output logic [XLEN-1:0]     d_rdata_o,

  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [XLEN/8-1:0]   mem_be_o,
  output logic [XLEN-1:0]     mem_addr_o,
  output logic [XLEN-1:0]     mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [XLEN-1:0]     mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_GNT = 2'd1,
    S_WAIT_RSP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_DATA = 1'b0,
    OWN_IF   = 1'b1
  } owner_e;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  state_e     state_q;
  owner_e     owner_q;
  logic       kill_q;
  logic [3:0] streak_q;

  logic       streak_full;
  owner_e     sel_owner;
  owner_e     cur_owner;
  logic       req_raw;

  // Arbitration only matters in IDLE; afterwards the latched owner holds the port.
  always_comb begin
    streak_full = (streak_q == STREAK_MAX);
    if (d_req_i && !(if_req_i && streak_full)) begin
      sel_owner = OWN_DATA;
    end else begin
      sel_owner = OWN_IF;
    end
    cur_owner = (state_q == S_IDLE) ? sel_owner : owner_q;

    unique case (state_q)
      S_IDLE:     req_raw = if_req_i | d_req_i;
      S_WAIT_GNT: req_raw = 1'b1;
      default:    req_raw = 1'b0;
    endcase
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if_gnt_o    = 1'b0;
    d_gnt_o     = 1'b0;
    if_rvalid_o = 1'b0;
    d_rvalid_o  = 1'b0;
    if_rdata_o  = '0;
    d_rdata_o   = '0;
    if (!rst_i) begin
      mem_req_o = req_raw;
      if (cur_owner == OWN_IF) begin
        mem_we_o    = 1'b0;
        mem_be_o    = '1;
        mem_addr_o  = if_addr_i;
        mem_wdata_o = '0;
      end else begin
        mem_we_o    = d_we_i;
        mem_be_o    = d_be_i;
        mem_addr_o  = d_addr_i;
        mem_wdata_o = d_wdata_i;
      end
      if_gnt_o = mem_gnt_i & req_raw & (cur_owner == OWN_IF);
      d_gnt_o  = mem_gnt_i & req_raw & (cur_owner == OWN_DATA);

      // A flush arriving with the response itself must also drop it.
      d_rvalid_o  = mem_rvalid_i & (state_q == S_WAIT_RSP) & (owner_q == OWN_DATA);
      if_rvalid_o = mem_rvalid_i & (state_q == S_WAIT_RSP) & (owner_q == OWN_IF)
                    & ~kill_q & ~if_flush_i;
      if_rdata_o  = mem_rdata_i;
      d_rdata_o   = mem_rdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      owner_q  <= OWN_DATA;
      kill_q   <= 1'b0;
      streak_q <= 4'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_raw) begin
            owner_q <= sel_owner;
            state_q <= mem_gnt_i ? S_WAIT_RSP : S_WAIT_GNT;
            if (if_gnt_o && if_flush_i) begin
              kill_q <= 1'b1;
            end
          end
        end
        S_WAIT_GNT: begin
          if (owner_q == OWN_IF && if_flush_i) begin
            kill_q <= 1'b1;
          end
          if (mem_gnt_i) begin
            state_q <= S_WAIT_RSP;
          end
        end
        S_WAIT_RSP: begin
          if (mem_rvalid_i) begin
            state_q <= S_IDLE;
            kill_q  <= 1'b0;
          end else if (owner_q == OWN_IF && if_flush_i) begin
            kill_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase

      // Streak counts data grants taken while a fetch was waiting.
      if (d_gnt_o) begin
        if (!if_req_i) begin
          streak_q <= 4'd0;
        end else if (!streak_full) begin
          streak_q <= streak_q + 4'd1;
        end
      end else if (if_gnt_o) begin
        streak_q <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Scoreboard bench for riscv_mem_arbiter: directed scenarios, then randomized
// traffic against a word-addressed reference memory and a fairness bound.
module tb_riscv_mem_arbiter;

  localparam int MAXS = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i, if_flush_i, if_gnt_o, if_rvalid_o;
  logic [31:0] if_addr_i, if_rdata_o;
  logic        d_req_i, d_we_i, d_gnt_o, d_rvalid_o;
  logic [3:0]  d_be_i;
  logic [31:0] d_addr_i, d_wdata_i, d_rdata_o;
  logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  riscv_mem_arbiter #(.XLEN(32), .MAX_D_STREAK(MAXS)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        chk_data;
    logic [31:0] data;
  } exp_t;

  exp_t if_q[$];
  exp_t d_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic [31:0] ref_mem  [logic [31:0]];
  logic [31:0] phys_mem [logic [31:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] phys_rd(input logic [31:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : init_word(a);
  endfunction

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  // Monitor: every response the DUT presents must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (if_rvalid_o) begin
        if (if_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL if_rsp_unexpected: actual rvalid data %0h required no response", if_rdata_o);
        end else begin
          e = if_q.pop_front();
          chk("if_rdata", if_rdata_o, e.data);
        end
      end
      if (d_rvalid_o) begin
        if (d_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL d_rsp_unexpected: actual rvalid data %0h required no response", d_rdata_o);
        end else begin
          e = d_q.pop_front();
          if (e.chk_data) chk("d_rdata", d_rdata_o, e.data);
          else n_cmp++;
        end
      end
    end
  end

  initial begin
    logic        if_pend, if_out, d_pend, rsp_busy, drain;
    int          rsp_cnt, dstreak;
    logic [31:0] rsp_data, m;

    rst_i = 1'b1;
    if_req_i = 1'b1; if_addr_i = 32'h40; if_flush_i = 1'b0;
    d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'hF; d_addr_i = 32'h1000; d_wdata_i = 32'hFFFF_FFFF;
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;

    // Reset: every output forced low even with live inputs.
    smp();
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_gnt", {if_gnt_o, d_gnt_o}, 0);
    chk("rst_rvalid", {if_rvalid_o, d_rvalid_o}, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_mem_wdata", mem_wdata_o, 0);
    chk("rst_rdata", if_rdata_o | d_rdata_o, 0);
    cyc();
    rst_i = 1'b0; if_req_i = 0; d_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;

    // Single fetch.
    cyc(); if_req_i = 1; if_addr_i = 32'h100; mem_gnt_i = 1;
    smp();
    chk("t1_if_gnt", if_gnt_o, 1); chk("t1_d_gnt", d_gnt_o, 0);
    chk("t1_addr", mem_addr_o, 32'h100); chk("t1_we_be", {mem_we_o, mem_be_o}, 5'h0F);
    if_q.push_back('{1'b1, 32'h0050_0093});
    cyc(); if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h0050_0093;
    smp(); chk("t1_if_rvalid", if_rvalid_o, 1); chk("t1_d_rvalid", d_rvalid_o, 0);
    cyc(); mem_rvalid_i = 0;

    // Simultaneous requests: data first, fetch on the next IDLE.
    cyc(); if_req_i = 1; if_addr_i = 32'h200; d_req_i = 1; d_we_i = 0; d_addr_i = 32'h1000; mem_gnt_i = 1;
    smp(); chk("t2_d_gnt", d_gnt_o, 1); chk("t2_if_gnt", if_gnt_o, 0); chk("t2_addr", mem_addr_o, 32'h1000);
    d_q.push_back('{1'b1, 32'h1111_1111});
    cyc(); d_req_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h1111_1111;
    smp(); chk("t2_no_arb_in_rvalid", if_gnt_o, 0);
    cyc(); mem_rvalid_i = 0;
    smp(); chk("t2_if_gnt_next", if_gnt_o, 1); chk("t2_if_addr", mem_addr_o, 32'h200);
    if_q.push_back('{1'b1, 32'h2222_2222});
    cyc(); if_req_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h2222_2222;
    cyc(); mem_rvalid_i = 0;

    // Starvation: four data grants, then one fetch, repeating.
    d_req_i = 1; d_we_i = 1; d_be_i = 4'hF; if_req_i = 1; if_addr_i = 32'h500; mem_gnt_i = 1;
    for (int g = 0; g < 14; g++) begin
      d_addr_i = 32'h1100 + 32'(g) * 4; d_wdata_i = 32'(g);
      smp();
      chk($sformatf("t3_if_gnt_%0d", g), if_gnt_o, (g % 5 == 4));
      chk($sformatf("t3_d_gnt_%0d", g), d_gnt_o, (g % 5 != 4));
      if (g % 5 == 4) if_q.push_back('{1'b1, 32'hCAFE_0000 + 32'(g)});
      else d_q.push_back('{1'b0, 32'h0});
      cyc(); mem_rvalid_i = 1; mem_rdata_i = 32'hCAFE_0000 + 32'(g);
      smp(); chk("t3_no_gnt_rsp", {if_gnt_o, d_gnt_o}, 0);
      cyc(); mem_rvalid_i = 0;
    end
    if_req_i = 0; d_req_i = 0; mem_gnt_i = 0;

    // Flush during WAIT_RSP drops the response.
    cyc(); if_req_i = 1; if_addr_i = 32'h300; mem_gnt_i = 1;
    smp(); chk("t4_if_gnt", if_gnt_o, 1);
    cyc(); if_req_i = 0; mem_gnt_i = 0; if_flush_i = 1;
    cyc(); if_flush_i = 0;
    cyc();
    cyc(); mem_rvalid_i = 1; mem_rdata_i = 32'h3333_3333;
    smp(); chk("t4_if_rvalid_dropped", if_rvalid_o, 0);
    cyc(); mem_rvalid_i = 0; d_req_i = 1; d_we_i = 0; d_addr_i = 32'h1004; mem_gnt_i = 1;
    smp(); chk("t4_next_d_gnt", d_gnt_o, 1);
    d_q.push_back('{1'b1, 32'h4444_4444});
    cyc(); d_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h4444_4444;
    cyc(); mem_rvalid_i = 0;

    // Backpressure: payload held stable, fetch waits until after the data response.
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (k == 0) begin
        d_req_i = 1; d_we_i = 1; d_be_i = 4'hF; d_addr_i = 32'h1008; d_wdata_i = 32'hDEAD_BEEF;
      end
      if (k == 1) begin if_req_i = 1; if_addr_i = 32'h400; end
      mem_gnt_i = (k == 3);
      smp();
      chk($sformatf("t5_req_%0d", k), mem_req_o, 1);
      chk($sformatf("t5_addr_%0d", k), mem_addr_o, 32'h1008);
      chk($sformatf("t5_wdata_%0d", k), mem_wdata_o, 32'hDEAD_BEEF);
      chk($sformatf("t5_we_be_%0d", k), {mem_we_o, mem_be_o}, 5'h1F);
      chk($sformatf("t5_gnts_%0d", k), {if_gnt_o, d_gnt_o}, {1'b0, k == 3});
    end
    d_q.push_back('{1'b0, 32'h0});
    cyc(); d_req_i = 0; mem_gnt_i = 1;
    smp(); chk("t5_if_wait_rsp", if_gnt_o, 0);
    cyc(); mem_rvalid_i = 1; mem_rdata_i = 32'h0;
    smp(); chk("t5_if_wait_rvalid", if_gnt_o, 0); chk("t5_d_rvalid", d_rvalid_o, 1);
    cyc(); mem_rvalid_i = 0;
    smp(); chk("t5_if_gnt", if_gnt_o, 1); chk("t5_if_addr", mem_addr_o, 32'h400);
    if_q.push_back('{1'b1, 32'h5555_5555});
    cyc(); if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h5555_5555;
    cyc(); mem_rvalid_i = 0;

    // Reset while waiting for a response: the late response is ignored.
    cyc(); d_req_i = 1; d_we_i = 0; d_addr_i = 32'h100C; mem_gnt_i = 1;
    smp(); chk("t6_d_gnt", d_gnt_o, 1);
    cyc(); d_req_i = 0; rst_i = 1; if_req_i = 1; mem_rdata_i = 32'h7777_7777;
    smp();
    chk("t6_rst_req", mem_req_o, 0); chk("t6_rst_gnt", {if_gnt_o, d_gnt_o}, 0);
    chk("t6_rst_addr", mem_addr_o, 0); chk("t6_rst_rdata", if_rdata_o, 0);
    cyc(); rst_i = 0; if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h6666_6666;
    smp(); chk("t6_late_rvalid", {if_rvalid_o, d_rvalid_o}, 0); chk("t6_idle_req", mem_req_o, 0);
    cyc(); mem_rvalid_i = 0; if_req_i = 1; if_addr_i = 32'h600; mem_gnt_i = 1;
    smp(); chk("t6_if_gnt_idle", if_gnt_o, 1);
    if_q.push_back('{1'b1, 32'h6767_6767});
    cyc(); if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h6767_6767;
    cyc(); mem_rvalid_i = 0;

    // Randomized traffic against the reference memory.
    if_pend = 0; if_out = 0; d_pend = 0; rsp_busy = 0; rsp_cnt = 0; dstreak = 0; rsp_data = 0;
    for (int c = 0; c < 3040; c++) begin
      drain = (c >= 3000);
      cyc();
      mem_rvalid_i = 0;
      if (rsp_busy) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin mem_rvalid_i = 1; mem_rdata_i = rsp_data; end
      end else if ($urandom_range(9) == 0) begin
        mem_rvalid_i = 1; mem_rdata_i = $urandom;
      end
      mem_gnt_i = drain ? 1'b1 : ($urandom_range(9) < 7);

      if_flush_i = 0;
      if (!drain && !if_pend && $urandom_range(1) == 1) begin
        if_pend = 1; if_addr_i = 32'($urandom_range(255)) << 2;
      end
      if (!drain && if_out && $urandom_range(5) == 0) begin
        if_flush_i = 1; if_out = 0;
        if (if_q.size() > 0) void'(if_q.pop_back());
      end else if (!drain && !if_pend && !if_out && $urandom_range(7) == 0) begin
        if_flush_i = 1;
      end
      if_req_i = if_pend;

      if (!drain && !d_pend && $urandom_range(1) == 1) begin
        d_pend = 1; d_we_i = 1'($urandom_range(1)); d_be_i = 4'($urandom_range(15, 1));
        d_addr_i = 32'h1000 + 32'($urandom_range(15)) * 4; d_wdata_i = $urandom;
      end
      d_req_i = d_pend;

      smp();
      chk("r_gnt_match", {if_gnt_o | d_gnt_o}, mem_req_o & mem_gnt_i);
      if (rsp_busy) chk("r_no_req_in_rsp", mem_req_o, 0);
      if (if_gnt_o) begin
        chk("r_if_gnt_requested", if_pend, 1);
        if_q.push_back('{1'b1, ref_rd(if_addr_i)});
        if_pend = 0; if_out = 1; dstreak = 0;
      end
      if (d_gnt_o) begin
        chk("r_d_gnt_requested", d_pend, 1);
        if (d_we_i) begin
          m = be_mask(d_be_i);
          ref_mem[d_addr_i] = (ref_rd(d_addr_i) & ~m) | (d_wdata_i & m);
          d_q.push_back('{1'b0, 32'h0});
        end else begin
          d_q.push_back('{1'b1, ref_rd(d_addr_i)});
        end
        if (if_req_i) begin
          dstreak++;
          chk("r_if_starve_bound", dstreak <= MAXS, 1);
        end else begin
          dstreak = 0;
        end
        d_pend = 0;
      end
      if (if_rvalid_o) if_out = 0;
      if (rsp_busy && mem_rvalid_i) rsp_busy = 0;
      if (mem_req_o && mem_gnt_i) begin
        if (mem_we_o) begin
          m = be_mask(mem_be_o);
          phys_mem[mem_addr_o] = (phys_rd(mem_addr_o) & ~m) | (mem_wdata_o & m);
          rsp_data = $urandom;
        end else begin
          rsp_data = phys_rd(mem_addr_o);
        end
        rsp_busy = 1; rsp_cnt = $urandom_range(3, 1);
      end
    end

    chk("end_if_q_empty", if_q.size(), 0);
    chk("end_d_q_empty", d_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
- Shares one single-port memory between instruction fetch (IF) and data access (MEM stage).
- Sits between the fetch/load-store logic and the memory interface.
- Allows one outstanding transaction at a time. Arbitration is data-priority with an anti-starvation limit for fetch.
- Discards fetch responses killed by a branch flush.

Parameters:
- XLEN, 32, address/data width.
- MAX_D_STREAK, 4, consecutive data grants allowed while a fetch is waiting; range 1..15.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-high reset
- if_req_i  input  1  fetch request; held with if_addr_i until if_gnt_o
- if_addr_i  input  XLEN  fetch address
- if_flush_i  input  1  branch taken; kill any in-flight fetch
- if_gnt_o  output  1  fetch request accepted by memory
- if_rvalid_o  output  1  fetch data valid
- if_rdata_o  output  XLEN  fetched instruction
- d_req_i  input  1  data request; held with payload until d_gnt_o
- d_we_i  input  1  1 = write
- d_be_i  input  XLEN/8  byte enables
- d_addr_i  input  XLEN  data address
- d_wdata_i  input  XLEN  write data
- d_gnt_o  output  1  data request accepted
- d_rvalid_o  output  1  data response (read data, or write done)
- d_rdata_o  output  XLEN  read data
- mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o  output  1/1/XLEN/8/XLEN/XLEN  memory request
- mem_gnt_i  input  1  memory accepts the request this cycle
- mem_rvalid_i  input  1  memory response; one per granted request, including writes, at least 1 cycle after grant
- mem_rdata_i  input  XLEN  memory read data

Behaviour:
- Reset: clk_i is the only clock; reset is synchronous, active-high, on rst_i.
  - Reset sets state=IDLE, owner=DATA, kill=0, streak=0.
  - While rst_i=1: mem_req_o, if_gnt_o, d_gnt_o, if_rvalid_o and d_rvalid_o are forced to 0; all data outputs are 0.
- FSM states: IDLE, WAIT_GNT, WAIT_RSP.
- IDLE arbitration (combinational):
  - If d_req_i=1 and not (if_req_i=1 and streak==MAX_D_STREAK), select DATA.
  - Else if if_req_i=1, select IF.
  - mem_req_o = if_req_i | d_req_i. The mem_* payload is muxed from the selected requester; mem_we_o=0 and mem_be_o=all-ones for IF.
- Owner and grant:
  - The selected owner is registered whenever mem_req_o=1 in IDLE.
  - x_gnt_o = mem_gnt_i & mem_req_o & (selected or registered owner == x). Grant is combinational, zero latency.
- Transitions:
  - IDLE -> WAIT_RSP on request with mem_gnt_i=1.
  - IDLE -> WAIT_GNT on request with mem_gnt_i=0.
  - WAIT_GNT: keep mem_req_o=1 with the latched owner's payload. Never re-arbitrate or withdraw. On mem_gnt_i=1 -> WAIT_RSP.
  - WAIT_RSP: mem_req_o=0. On mem_rvalid_i=1 -> IDLE.
  - Minimum 2 cycles per transaction. A new arbitration happens only in IDLE, never in the rvalid cycle.
- Responses:
  - if_rdata_o and d_rdata_o = mem_rdata_i (pass-through).
  - d_rvalid_o = mem_rvalid_i & WAIT_RSP & owner==DATA.
  - if_rvalid_o = mem_rvalid_i & WAIT_RSP & owner==IF & ~kill & ~if_flush_i.
  - mem_rvalid_i in IDLE or WAIT_GNT is ignored.
- Flush:
  - if_flush_i while an IF transaction is in WAIT_GNT, WAIT_RSP, or being granted in IDLE sets kill=1.
  - The request still completes at the memory, but its response is dropped.
  - kill clears on return to IDLE.
  - if_flush_i with no IF transaction is ignored.
  - A flush in the same cycle as the rvalid drops that response.
- Streak counter (4 bits, saturating at MAX_D_STREAK):
  - +1 when DATA is granted while if_req_i=1.
  - Cleared to 0 on any IF grant, and when DATA is granted while if_req_i=0.
- Reset mid-transaction: returns to IDLE. A late mem_rvalid_i is ignored, and no rvalid reaches either requester.

Test Plan:
- Single fetch: if_req_i=1, addr 0x100, mem_gnt_i=1 same cycle, rvalid 1 cycle later with 0x00500093 -> if_gnt_o=1 in cycle 0; if_rvalid_o=1 and if_rdata_o=0x00500093 in cycle 1; d_* outputs stay 0.
- Simultaneous requests: if_req_i=1 @0x200 and d_req_i=1 read @0x1000, memory always grants -> data served first (mem_addr_o=0x1000), then fetch at 0x200 on the next IDLE.
- Starvation: d_req_i held high for 12 back-to-back writes, if_req_i held high, MAX_D_STREAK=4 -> exactly 4 data grants, 1 IF grant, 4 data grants, and so on; streak visible resetting to 0.
- Flush: IF granted @0x300, if_flush_i pulsed in WAIT_RSP, mem_rvalid_i 3 cycles later -> if_rvalid_o stays 0; next request accepted in the following IDLE cycle.
- Backpressure: d_req_i write 0xDEADBEEF, be=0xF, mem_gnt_i low for 3 cycles while if_req_i rises -> payload stable on mem_* for all 4 cycles; fetch not granted until after the data rvalid.
- Reset in WAIT_RSP: rst_i=1 for one cycle, then mem_rvalid_i=1 -> no rvalid on either side; state IDLE; outputs 0 during reset.
